// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Purpose : bundles the producer-side request/ack bus and the transmitter-side
//           load/busy handshake of the UART TX arbiter.
// Signals : req_valid/req_data/req_ack - NUM_REQ byte producers
//           req_lock                   - per-requester message lock
//                                        (only with UART_TX_ARB_LOCK_EN)
//           tx_load/tx_data/tx_busy    - shared UART transmitter
//           grant_id/arb_busy/err_timeout - status
// Modports: master - the arbiter; slave - the surrounding environment.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      tx_load;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;
    logic [ID_W-1:0]           grant_id;
    logic                      arb_busy;
    logic                      err_timeout;
`ifdef UART_TX_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;
`endif

    modport master (
`ifdef UART_TX_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req_data, tx_busy,
        output req_ack, tx_load, tx_data, grant_id, arb_busy, err_timeout
    );

    modport slave (
`ifdef UART_TX_ARB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req_data, tx_busy,
        input  req_ack, tx_load, tx_data, grant_id, arb_busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Purpose : shares one UART transmitter between NUM_REQ byte producers using
//           round-robin arbitration. Each frame is sequenced as
//           IDLE -> LOAD -> FRAME -> GAP -> IDLE (LOAD -> GAP on timeout,
//           GAP skipped when GAP_CYCLES = 0).
// Ports   : clk      - system clock
//           areset_n - asynchronous active-low reset (sync release expected)
//           bus      - uart_tx_arbiter_if.master (requests, acks, TX handshake,
//                      grant_id, arb_busy, err_timeout)
// Options : UART_TX_ARB_LOCK_EN - when defined, req_lock[grant_id] held high
//           at the end of a frame re-grants the same requester (if it still
//           has a byte) without advancing the round-robin pointer.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int LOAD_TIMEOUT = 1024,
    parameter int GAP_CYCLES   = 16
) (
    input  logic              clk,
    input  logic              areset_n,
    uart_tx_arbiter_if.master bus
);
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_MAX = (LOAD_TIMEOUT > GAP_CYCLES) ? LOAD_TIMEOUT : GAP_CYCLES;
    // Counter only ever holds terminal-1, so clog2 of the larger limit suffices.
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FRAME = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ID_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_load;
    logic [DATA_W-1:0]   r_data;
    logic [ID_W-1:0]     r_grant;
    logic                r_busy;
    logic                r_err;
    logic                r_hold;

    logic [ID_W:0]       w_pos;
    logic [ID_W-1:0]     w_rr_idx;
    logic                w_rr_hit;
    logic                w_lock_now;
    logic                w_keep;
    logic [ID_W-1:0]     w_sel_idx;
    logic                w_sel_hit;
    logic [NUM_REQ-1:0]  w_sel_onehot;
    logic [DATA_W-1:0]   w_sel_data;
    logic [ID_W-1:0]     w_next_ptr;

    // Round-robin search starting at r_ptr. Iterating from the farthest
    // position down lets the nearest hit overwrite, so no "found" flag needed.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        w_pos    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, r_ptr} + (ID_W + 1)'(k);
            if (w_pos >= (ID_W + 1)'(NUM_REQ)) begin
                w_pos = w_pos - (ID_W + 1)'(NUM_REQ);
            end
            if (bus.req_valid[w_pos[ID_W-1:0]]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = w_pos[ID_W-1:0];
            end
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    assign w_lock_now = bus.req_lock[r_grant];
`else
    assign w_lock_now = 1'b0;
`endif

    // r_hold remembers that the last owner was locked when the frame ended;
    // it only wins if that owner still presents a byte.
    assign w_keep       = r_hold & bus.req_valid[r_grant];
    assign w_sel_idx    = w_keep ? r_grant : w_rr_idx;
    assign w_sel_hit    = w_keep | w_rr_hit;
    assign w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
    assign w_next_ptr   = (w_sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_sel_idx + 1'b1;

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel_idx == ID_W'(k)) begin
                w_sel_data = bus.req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_ack   <= '0;
            r_load  <= 1'b0;
            r_data  <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_hit) begin
                        r_ack   <= w_sel_onehot;
                        r_load  <= 1'b1;
                        r_data  <= w_sel_data;
                        r_grant <= w_sel_idx;
                        r_busy  <= 1'b1;
                        r_hold  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                        if (!w_keep) begin
                            r_ptr <= w_next_ptr;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.tx_busy) begin
                        r_load  <= 1'b0;
                        r_state <= S_FRAME;
                    end else if (r_cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
                        // Transmitter never took the byte: drop it and report.
                        r_load <= 1'b0;
                        r_err  <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_hold  <= w_lock_now;
                        end else begin
                            r_state <= S_GAP;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FRAME: begin
                    if (!bus.tx_busy) begin
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_hold  <= w_lock_now;
                        end else begin
                            r_state <= S_GAP;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_hold  <= w_lock_now;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_load  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ack     = r_ack;
    assign bus.tx_load     = r_load;
    assign bus.tx_data     = r_data;
    assign bus.grant_id    = r_grant;
    assign bus.arb_busy    = r_busy;
    assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Purpose : self-checking bench for uart_tx_arbiter. A behavioural UART
//           transmitter answers tx_load after a programmable number of cycles
//           and stays busy for a programmable frame length. A second instance
//           runs with GAP_CYCLES = 0 and a short LOAD_TIMEOUT.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int DATA_W       = 8;
    localparam int LOAD_TIMEOUT = 1024;
    localparam int GAP_CYCLES   = 16;
    localparam int Z_TIMEOUT    = 4;

    logic clk = 1'b0;
    logic areset_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();
    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) busz ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W),
                      .LOAD_TIMEOUT(LOAD_TIMEOUT), .GAP_CYCLES(GAP_CYCLES))
        u_dut (.clk(clk), .areset_n(areset_n), .bus(bus.master));

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W),
                      .LOAD_TIMEOUT(Z_TIMEOUT), .GAP_CYCLES(0))
        u_dut_z (.clk(clk), .areset_n(areset_n), .bus(busz.master));

    int n_tests = 0;
    int n_fail  = 0;
    int model_ptr = 0;
    int tb_dly  = 1;   // tx_load cycles before the transmitter accepts; 0 = never
    int tb_flen = 1;   // cycles tx_busy stays high once accepted

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first requesting index at or after p, wrapping.
    function automatic int pick(input logic [NUM_REQ-1:0] m, input int p);
        int mi;
        mi = int'(m);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (((mi >> ((p + k) % NUM_REQ)) & 1) == 1) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Behavioural transmitter for the main instance.
    initial begin
        int lc;
        int fc;
        lc = 0;
        fc = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk or negedge areset_n);
            if (!areset_n) begin
                bus.tx_busy = 1'b0;
                lc = 0;
                fc = 0;
            end else if (!bus.tx_busy) begin
                if (bus.tx_load) begin
                    lc++;
                    if (tb_dly != 0 && lc >= tb_dly) begin
                        bus.tx_busy = 1'b1;
                        lc = 0;
                        fc = 0;
                    end
                end else begin
                    lc = 0;
                end
            end else begin
                fc++;
                if (fc >= tb_flen) bus.tx_busy = 1'b0;
            end
        end
    end

    // One complete transaction on the main instance, started at a negedge
    // while the arbiter is idle; returns at the negedge where arb_busy is low.
    task automatic run_frame(input string tag, input logic [NUM_REQ-1:0] mask,
                             input logic [31:0] data, input int dly, input int flen,
                             input bit drop, input int forced);
        int g;
        logic [DATA_W-1:0] exp_byte;
        int cyc, ld, extra, errs, unstable, exp_ld, exp_cyc;
        g = (forced >= 0) ? forced : pick(mask, model_ptr);
        exp_byte = DATA_W'(data >> (g * DATA_W));
        tb_dly  = dly;
        tb_flen = flen;
        bus.req_data  = data;
        bus.req_valid = mask;
        @(negedge clk);
        chk({tag, ".ack"},  64'(bus.req_ack), 64'(1 << g));
        chk({tag, ".gid"},  64'(bus.grant_id), 64'(g));
        chk({tag, ".load"}, 64'(bus.tx_load), 64'd1);
        chk({tag, ".data"}, 64'(bus.tx_data), 64'(exp_byte));
        if (forced < 0) model_ptr = (g + 1) % NUM_REQ;
        if (drop) bus.req_valid = mask & ~(NUM_REQ'(1) << g);
        cyc = 1; ld = 1; extra = 0; errs = 0; unstable = 0;
        while (cyc < LOAD_TIMEOUT + 400) begin
            @(negedge clk);
            if (!bus.arb_busy) break;
            cyc++;
            if (bus.tx_load) ld++;
            if (bus.req_ack != '0) extra++;
            if (bus.err_timeout) errs++;
            if ((bus.tx_load || bus.tx_busy) && bus.tx_data !== exp_byte) unstable++;
        end
        exp_ld  = (dly == 0) ? LOAD_TIMEOUT : dly;
        exp_cyc = (dly == 0) ? LOAD_TIMEOUT + GAP_CYCLES : dly + flen + GAP_CYCLES;
        chk({tag, ".load_cycles"}, 64'(ld), 64'(exp_ld));
        chk({tag, ".busy_cycles"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, ".extra_ack"},   64'(extra), 64'd0);
        chk({tag, ".err_pulses"},  64'(errs), 64'((dly == 0) ? 1 : 0));
        chk({tag, ".data_stable"}, 64'(unstable), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        areset_n       = 1'b0;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        busz.req_valid = '0;
        busz.req_data  = '0;
        busz.tx_busy   = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        bus.req_lock   = '0;
        busz.req_lock  = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst.ack",  64'(bus.req_ack), 64'd0);
        chk("rst.load", 64'(bus.tx_load), 64'd0);
        chk("rst.data", 64'(bus.tx_data), 64'd0);
        chk("rst.gid",  64'(bus.grant_id), 64'd0);
        chk("rst.busy", 64'(bus.arb_busy), 64'd0);
        chk("rst.err",  64'(bus.err_timeout), 64'd0);
        areset_n = 1'b1;
        @(negedge clk);
        chk("idle.busy", 64'(bus.arb_busy), 64'd0);

        // Fairness: every requester held high, grants rotate 0,1,2,3,0,...
        model_ptr = 0;
        for (int i = 0; i < 8; i++) run_frame("rr", '1, $urandom, 2, 3, 1'b0, -1);

        // Single requester 2 with byte 0xA5, accepted after 3 load cycles.
        run_frame("single", 4'b0100, 32'h00A5_0000, 3, 4, 1'b1, -1);
        bus.req_valid = '0;

        // Randomised masks, data and transmitter timing.
        for (int i = 0; i < 24; i++) begin
            run_frame("rand", NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), $urandom,
                      int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), 1'b1, -1);
        end
        bus.req_valid = '0;

        // Transmitter never accepts: byte dropped after LOAD_TIMEOUT cycles.
        run_frame("tmo", 4'b0010, $urandom, 0, 1, 1'b1, -1);
        bus.req_valid = '0;

        // Asynchronous reset in the middle of a frame.
        tb_dly  = 2;
        tb_flen = 40;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("arst.ack", 64'(bus.req_ack), 64'b0010);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
        chk("arst.pre_busy", 64'(bus.arb_busy), 64'd1);
        chk("arst.pre_txb",  64'(bus.tx_busy), 64'd1);
        #2 areset_n = 1'b0;
        #1;
        chk("arst.load", 64'(bus.tx_load), 64'd0);
        chk("arst.ack0", 64'(bus.req_ack), 64'd0);
        chk("arst.busy", 64'(bus.arb_busy), 64'd0);
        chk("arst.gid",  64'(bus.grant_id), 64'd0);
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        chk("arst.no_replay", 64'(bus.req_ack), 64'd0);
        model_ptr = 0;
        run_frame("post_rst", '1, $urandom, 1, 2, 1'b1, -1);
        bus.req_valid = '0;

`ifdef UART_TX_ARB_LOCK_EN
        // Locked requester 3 keeps the transmitter for three bytes.
        bus.req_lock = 4'b1000;
        run_frame("lock1", 4'b1001, $urandom, 1, 2, 1'b0, -1);
        run_frame("lock2", 4'b1001, $urandom, 1, 2, 1'b0, 3);
        bus.req_lock = '0;
        run_frame("lock3", 4'b1001, $urandom, 1, 2, 1'b0, 3);
        run_frame("lock4", 4'b1001, $urandom, 1, 2, 1'b0, -1);
        bus.req_valid = '0;
`endif

        // Zero-gap instance: back-to-back requester 1.
        busz.req_data  = 32'h0000_3C00;
        busz.req_valid = 4'b0010;
        @(negedge clk);
        chk("z.ack1",  64'(busz.req_ack), 64'b0010);
        chk("z.load1", 64'(busz.tx_load), 64'd1);
        chk("z.data1", 64'(busz.tx_data), 64'h3C);
        busz.tx_busy = 1'b1;
        @(negedge clk);
        chk("z.accept", 64'(busz.tx_load), 64'd0);
        chk("z.frame",  64'(busz.arb_busy), 64'd1);
        busz.tx_busy = 1'b0;
        @(negedge clk);
        chk("z.nogap_idle", 64'(busz.arb_busy), 64'd0);
        chk("z.nogap_ack0", 64'(busz.req_ack), 64'd0);
        @(negedge clk);
        chk("z.ack2", 64'(busz.req_ack), 64'b0010);
        n = 0;
        while (busz.tx_load && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("z.tmo_cycles", 64'(n), 64'(Z_TIMEOUT));
        chk("z.tmo_err",    64'(busz.err_timeout), 64'd1);
        chk("z.tmo_idle",   64'(busz.arb_busy), 64'd0);
        busz.req_valid = '0;
        @(negedge clk);
        chk("z.err_pulse", 64'(busz.err_timeout), 64'd0);
        chk("z.ack_none",  64'(busz.req_ack), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
